store_queue_fwd: RTL and testbench

//  Parametrised store data queue for the load/store unit with in-order commit and drain to the cache controller.

---
 rtl/store_queue_fwd.sv | 213 +++++++++++++++++++++
 tb/tb_store_queue_fwd.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_queue_fwd.sv
// Store data queue: in-order allocate/commit/drain toward the cache controller,
// with byte-granular store-to-load forwarding on NUM_LD_PORTS lookup ports.
module store_queue_fwd #(
    parameter int  XLEN         = 32,
    parameter int  ADDR_W       = 32,
    parameter int  DEPTH        = 8,
    parameter int  NUM_LD_PORTS = 2,
    localparam int IDX_W        = $clog2(DEPTH),
    localparam int PTR_W        = IDX_W + 1,
    localparam int NB           = XLEN / 8,
    localparam int LANE_W       = $clog2(NB)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           disp_vld_i,
    output logic [PTR_W-1:0]               sdq_alloc_idx_o,
    output logic                           sdq_full_o,
    output logic [IDX_W:0]                 sdq_count_o,
    input  logic                           exec_vld_i,
    input  logic [IDX_W-1:0]               exec_idx_i,
    input  logic [ADDR_W-1:0]              exec_addr_i,
    input  logic [XLEN-1:0]                exec_data_i,
    input  logic [1:0]                     exec_size_i,
    input  logic                           cmit_vld_i,
    output logic                           issue_vld_o,
    input  logic                           issue_rdy_i,
    output logic [ADDR_W-1:0]              issue_addr_o,
    output logic [XLEN-1:0]                issue_data_o,
    output logic [NB-1:0]                  issue_be_o,
    input  logic [NUM_LD_PORTS-1:0]        ld_vld_i,
    input  logic [NUM_LD_PORTS*ADDR_W-1:0] ld_addr_i,
    input  logic [NUM_LD_PORTS*2-1:0]      ld_size_i,
    input  logic [NUM_LD_PORTS*PTR_W-1:0]  ld_sdq_marker_i,
    output logic [NUM_LD_PORTS-1:0]        ld_hit_o,
    output logic [NUM_LD_PORTS-1:0]        ld_stall_o,
    output logic [NUM_LD_PORTS*XLEN-1:0]   ld_data_o
);

    function automatic logic [NB-1:0] size_mask(input logic [1:0] size);
        logic [NB-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) begin
            m[b] = (b < (1 << size));
        end
        return m;
    endfunction

    function automatic logic [XLEN-1:0] byte_expand(input logic [NB-1:0] m);
        logic [XLEN-1:0] r;
        r = '0;
        for (int b = 0; b < NB; b++) begin
            r[8*b +: 8] = {8{m[b]}};
        end
        return r;
    endfunction

    logic [PTR_W-1:0]  head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [DEPTH-1:0]  valid_q, valid_d, avld_q, avld_d, cmtd_q, cmtd_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [NB-1:0]     mask_q [DEPTH];

    logic [IDX_W-1:0]  head_idx, cmt_idx, tail_idx;
    logic [PTR_W-1:0]  count;
    logic              full;
    logic              disp_fire, exec_fire, cmit_fire, issue_fire;
    logic [LANE_W-1:0] exec_lane;

    assign head_idx  = head_q[IDX_W-1:0];
    assign cmt_idx   = cmt_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign count     = tail_q - head_q;
    assign full      = (count == PTR_W'(DEPTH));
    assign exec_lane = exec_addr_i[LANE_W-1:0];

    assign sdq_alloc_idx_o = tail_q;
    assign sdq_full_o      = full;
    assign sdq_count_o     = count;

    assign issue_vld_o  = valid_q[head_idx] & cmtd_q[head_idx] & avld_q[head_idx];
    assign issue_addr_o = addr_q[head_idx];
    assign issue_data_o = data_q[head_idx];
    assign issue_be_o   = mask_q[head_idx];

    assign disp_fire  = disp_vld_i & ~full & ~flush_i;
    assign exec_fire  = exec_vld_i & valid_q[exec_idx_i];
    assign cmit_fire  = cmit_vld_i & (cmt_q != tail_q);
    assign issue_fire = issue_vld_o & issue_rdy_i;

    always_comb begin
        head_d  = head_q;
        cmt_d   = cmt_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        avld_d  = avld_q;
        cmtd_d  = cmtd_q;
        if (disp_fire) begin
            valid_d[tail_idx] = 1'b1;
            avld_d[tail_idx]  = 1'b0;
            cmtd_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + PTR_W'(1);
        end
        if (exec_fire) begin
            avld_d[exec_idx_i] = 1'b1;
        end
        if (cmit_fire) begin
            cmtd_d[cmt_idx] = 1'b1;
            cmt_d           = cmt_q + PTR_W'(1);
        end
        if (issue_fire) begin
            valid_d[head_idx] = 1'b0;
            avld_d[head_idx]  = 1'b0;
            cmtd_d[head_idx]  = 1'b0;
            head_d            = head_q + PTR_W'(1);
        end
        // Flush sees the post-commit view, so a same-cycle commit survives.
        if (flush_i) begin
            tail_d = cmt_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (!cmtd_d[i]) begin
                    valid_d[i] = 1'b0;
                    avld_d[i]  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            avld_q  <= '0;
            cmtd_q  <= '0;
        end else begin
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            avld_q  <= avld_d;
            cmtd_q  <= cmtd_d;
        end
    end

    // Payload storage carries no reset; it is only observed behind addr_vld.
    always_ff @(posedge clk_i) begin
        if (exec_fire) begin
            addr_q[exec_idx_i] <= exec_addr_i;
            data_q[exec_idx_i] <= exec_data_i << {exec_lane, 3'b000};
            mask_q[exec_idx_i] <= size_mask(exec_size_i) << exec_lane;
        end
    end

    always_comb begin
        logic [PTR_W-1:0]  marker;
        logic [PTR_W-1:0]  span;
        logic [ADDR_W-1:0] laddr;
        logic [1:0]        lsize;
        logic [NB-1:0]     lmask;
        logic [NB-1:0]     fmask;
        logic [XLEN-1:0]   fdata;
        logic [IDX_W-1:0]  idx;
        logic              unres;
        logic              found;
        ld_hit_o   = '0;
        ld_stall_o = '0;
        ld_data_o  = '0;
        for (int p = 0; p < NUM_LD_PORTS; p++) begin
            marker = ld_sdq_marker_i[p*PTR_W +: PTR_W];
            span   = marker - head_q;
            laddr  = ld_addr_i[p*ADDR_W +: ADDR_W];
            lsize  = ld_size_i[p*2 +: 2];
            lmask  = size_mask(lsize) << laddr[LANE_W-1:0];
            unres  = 1'b0;
            found  = 1'b0;
            fmask  = '0;
            fdata  = '0;
            // Walk oldest to youngest so the last match is the youngest store.
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_idx + IDX_W'(k);
                if (valid_q[idx] && (PTR_W'(k) < span) && (span <= PTR_W'(DEPTH))) begin
                    if (!avld_q[idx]) begin
                        unres = 1'b1;
                    end else if ((addr_q[idx][ADDR_W-1:LANE_W] == laddr[ADDR_W-1:LANE_W]) &&
                                 ((mask_q[idx] & lmask) != '0)) begin
                        found = 1'b1;
                        fmask = mask_q[idx];
                        fdata = data_q[idx];
                    end
                end
            end
            if (ld_vld_i[p]) begin
                if (unres) begin
                    ld_stall_o[p] = 1'b1;
                end else if (found) begin
                    if ((fmask & lmask) == lmask) begin
                        ld_hit_o[p] = 1'b1;
                        ld_data_o[p*XLEN +: XLEN] = (fdata >> {laddr[LANE_W-1:0], 3'b000}) &
                                                    byte_expand(size_mask(lsize));
                    end else begin
                        ld_stall_o[p] = 1'b1;
                    end
                end
            end
        end
    end

    a_cmit_needs_addr: assert property (@(posedge clk_i) disable iff (!rst_i)
        cmit_fire |-> avld_q[cmt_idx]);

endmodule

// File: tb/tb_store_queue_fwd.sv
// Bench for store_queue_fwd: directed scenarios plus random traffic, scored
// against a queue-of-stores reference model.
module tb_store_queue_fwd;
    localparam int D  = 8;
    localparam int NP = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush, disp, exec_vld, cmit, issue_rdy;
    logic [2:0]  exec_idx;
    logic [31:0] exec_addr, exec_data;
    logic [1:0]  exec_size;
    logic [3:0]  alloc_idx;
    logic        full, issue_vld;
    logic [3:0]  count;
    logic [31:0] issue_addr, issue_data;
    logic [3:0]  issue_be;
    logic [1:0]  ld_vld, ld_hit, ld_stall;
    logic [63:0] ld_addr, ld_data;
    logic [3:0]  ld_size;
    logic [7:0]  ld_mark;

    store_queue_fwd #(.XLEN(32), .ADDR_W(32), .DEPTH(D), .NUM_LD_PORTS(NP)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush), .disp_vld_i(disp),
        .sdq_alloc_idx_o(alloc_idx), .sdq_full_o(full), .sdq_count_o(count),
        .exec_vld_i(exec_vld), .exec_idx_i(exec_idx), .exec_addr_i(exec_addr),
        .exec_data_i(exec_data), .exec_size_i(exec_size), .cmit_vld_i(cmit),
        .issue_vld_o(issue_vld), .issue_rdy_i(issue_rdy), .issue_addr_o(issue_addr),
        .issue_data_o(issue_data), .issue_be_o(issue_be), .ld_vld_i(ld_vld),
        .ld_addr_i(ld_addr), .ld_size_i(ld_size), .ld_sdq_marker_i(ld_mark),
        .ld_hit_o(ld_hit), .ld_stall_o(ld_stall), .ld_data_o(ld_data));

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [1:0] size; logic ex; logic cm;} st_t;
    typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] be;} iss_t;
    typedef struct packed {int port; logic hit; logic stall; logic [31:0] data;} ld_t;

    st_t  mq[$];
    iss_t exp_iss[$];
    ld_t  exp_ld[$];
    int   head_ptr = 0;
    int   ncmt = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic ld_t mk_ld(int p, logic h, logic s, logic [31:0] d);
        ld_t r;
        r.port = p; r.hit = h; r.stall = s; r.data = d;
        return r;
    endfunction

    function automatic iss_t mk_iss(st_t s);
        iss_t r;
        logic [31:0] t;
        t = ((32'd1 << (1 << s.size)) - 32'd1) << s.addr[1:0];
        r.addr = s.addr;
        r.data = s.data << (8 * s.addr[1:0]);
        r.be   = t[3:0];
        return r;
    endfunction

    // Reference forwarding: byte-interval overlap over the stores older than the marker.
    function automatic ld_t fwd_ref(int p, logic [31:0] la, int lsz, int mk);
        ld_t r;
        int span, lim, best, ln, sn;
        r = mk_ld(p, 1'b0, 1'b0, 32'h0);
        span = (mk - head_ptr + 16) % 16;
        lim = (span > D) ? 0 : span;
        if (lim > mq.size()) lim = mq.size();
        ln = 1 << lsz;
        best = -1;
        for (int k = 0; k < lim; k++) begin
            if (!mq[k].ex) r.stall = 1'b1;
            else begin
                sn = 1 << mq[k].size;
                if (mq[k].addr < la + ln && la < mq[k].addr + sn) best = k;
            end
        end
        if (r.stall || best < 0) return r;
        sn = 1 << mq[best].size;
        if (mq[best].addr <= la && la + ln <= mq[best].addr + sn) begin
            r.hit = 1'b1;
            for (int j = 0; j < ln; j++)
                r.data |= ((mq[best].data >> (8 * (la + j - mq[best].addr))) & 32'hFF) << (8 * j);
        end else r.stall = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        bit do_cm, do_dr;
        int k;
        st_t s;
        do_dr = mq.size() > 0 && mq[0].cm && issue_rdy;
        do_cm = cmit && ncmt < mq.size();
        if (exec_vld) begin
            k = (int'(exec_idx) - (head_ptr % D) + D) % D;
            if (k < mq.size()) begin
                mq[k].addr = exec_addr; mq[k].data = exec_data;
                mq[k].size = exec_size; mq[k].ex = 1'b1;
            end
        end
        if (do_cm) begin
            mq[ncmt].cm = 1'b1;
            exp_iss.push_back(mk_iss(mq[ncmt]));
            ncmt++;
        end
        if (disp && !flush && mq.size() < D) begin
            s = '0;
            mq.push_back(s);
        end
        if (do_dr) begin
            void'(mq.pop_front());
            head_ptr = (head_ptr + 1) % 16;
            ncmt--;
        end
        if (flush) while (mq.size() > ncmt) void'(mq.pop_back());
    endtask

    task automatic clr_inputs();
        disp = 0; exec_vld = 0; cmit = 0; flush = 0; ld_vld = '0;
        exec_idx = '0; exec_addr = '0; exec_data = '0; exec_size = '0;
        ld_addr = '0; ld_size = '0; ld_mark = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        clr_inputs();
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        mq.delete(); exp_iss.delete(); exp_ld.delete();
        head_ptr = 0; ncmt = 0;
        clr_inputs();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic set_exec(int idx, logic [31:0] a, logic [31:0] d, logic [1:0] s);
        exec_vld = 1; exec_idx = 3'(idx); exec_addr = a; exec_data = d; exec_size = s;
    endtask

    task automatic set_ld(int p, logic [31:0] a, logic [1:0] s, logic [3:0] mk, ld_t e);
        ld_vld[p] = 1'b1;
        ld_addr[p*32 +: 32] = a;
        ld_size[p*2 +: 2] = s;
        ld_mark[p*4 +: 4] = mk;
        exp_ld.push_back(e);
    endtask

    // Monitor: compares every observable output against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_i) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("full", 64'(full), 64'(mq.size() == D));
            chk("alloc", 64'(alloc_idx), 64'((head_ptr + mq.size()) % 16));
            chk("issue_vld", 64'(issue_vld), 64'(exp_iss.size() != 0));
            if (issue_vld && exp_iss.size() != 0) begin
                chk("issue_addr", 64'(issue_addr), 64'(exp_iss[0].addr));
                chk("issue_data", 64'(issue_data), 64'(exp_iss[0].data));
                chk("issue_be", 64'(issue_be), 64'(exp_iss[0].be));
                if (issue_rdy) void'(exp_iss.pop_front());
            end
            for (int p = 0; p < NP; p++) begin
                if (ld_vld[p]) begin
                    if (exp_ld.size() == 0) begin
                        chk("ld_expect_present", 64'd0, 64'd1);
                    end else begin
                        ld_t e;
                        e = exp_ld.pop_front();
                        chk("ld_port", 64'(p), 64'(e.port));
                        chk("ld_hit", 64'(ld_hit[p]), 64'(e.hit));
                        chk("ld_stall", 64'(ld_stall[p]), 64'(e.stall));
                        if (e.hit) chk("ld_data", 64'(ld_data[p*32 +: 32]), 64'(e.data));
                    end
                end else begin
                    chk("ld_idle_hit", 64'(ld_hit[p]), 64'd0);
                    chk("ld_idle_stall", 64'(ld_stall[p]), 64'd0);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b0;
        issue_rdy = 1'b0;
        clr_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_alloc", 64'(alloc_idx), 64'd0);
        chk("rst_issue_vld", 64'(issue_vld), 64'd0);

        // Fill, overflow, forward, hold, drain and wrap.
        repeat (8) begin disp = 1; tick(); end
        chk("full_at_8", 64'(full), 64'd1);
        disp = 1; tick();
        chk("ninth_ignored", 64'(count), 64'd8);
        set_exec(0, 32'h1000, 32'hDEADBEEF, 2'd2); tick();
        set_ld(0, 32'h1002, 2'd0, 4'd1, mk_ld(0, 1'b1, 1'b0, 32'h000000AD)); tick();
        cmit = 1; tick();
        repeat (3) begin
            tick();
            chk("hold_vld", 64'(issue_vld), 64'd1);
            chk("hold_data", 64'(issue_data), 64'hDEADBEEF);
            chk("hold_addr", 64'(issue_addr), 64'h1000);
        end
        chk("wrap_pre", 64'(alloc_idx), 64'b1000);
        issue_rdy = 1; tick(); issue_rdy = 0;
        chk("drain_count", 64'(count), 64'd7);
        disp = 1; tick();
        chk("wrap_post", 64'(alloc_idx), 64'b1001);
        chk("wrap_full", 64'(full), 64'd1);

        // Partial overlap, exact byte hit, no overlap, unresolved older store.
        set_exec(1, 32'h1001, 32'h55, 2'd0); tick();
        set_ld(0, 32'h1000, 2'd2, 4'd2, mk_ld(0, 1'b0, 1'b1, 32'h0));
        set_ld(1, 32'h1001, 2'd0, 4'd2, mk_ld(1, 1'b1, 1'b0, 32'h55));
        tick();
        set_ld(0, 32'h1003, 2'd0, 4'd2, mk_ld(0, 1'b0, 1'b0, 32'h0));
        set_ld(1, 32'h1001, 2'd0, 4'd3, mk_ld(1, 1'b0, 1'b1, 32'h0));
        tick();

        // Reset with five live entries, one of them ready to drain.
        do_reset();
        repeat (5) begin disp = 1; tick(); end
        set_exec(0, 32'h1004, 32'h12345678, 2'd2); tick();
        cmit = 1; tick();
        chk("pre_rst_vld", 64'(issue_vld), 64'd1);
        chk("pre_rst_count", 64'(count), 64'd5);
        do_reset();
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_vld", 64'(issue_vld), 64'd0);
        chk("mid_rst_alloc", 64'(alloc_idx), 64'd0);

        // Flush keeps the two committed stores, which then drain in order.
        repeat (4) begin disp = 1; tick(); end
        for (int k = 0; k < 4; k++) begin
            set_exec(k, 32'h1000 + 32'(4 * k), 32'h100 + 32'(k), 2'd2); tick();
        end
        cmit = 1; tick();
        cmit = 1; tick();
        flush = 1; tick();
        chk("flush_count", 64'(count), 64'd2);
        issue_rdy = 1;
        repeat (3) tick();
        issue_rdy = 0;
        chk("flush_alloc", 64'(alloc_idx), 64'd2);
        chk("flush_drained", 64'(count), 64'd0);

        // Two ports with different markers see different stores.
        do_reset();
        repeat (3) begin disp = 1; tick(); end
        set_exec(0, 32'h2000, 32'hAAAA0001, 2'd2); tick();
        set_exec(1, 32'h3000, 32'h11223344, 2'd2); tick();
        set_exec(2, 32'h2000, 32'hBBBB0002, 2'd2); tick();
        set_ld(0, 32'h2000, 2'd2, 4'd1, mk_ld(0, 1'b1, 1'b0, 32'hAAAA0001));
        set_ld(1, 32'h2000, 2'd2, 4'd3, mk_ld(1, 1'b1, 1'b0, 32'hBBBB0002));
        tick();
        set_ld(0, 32'h2002, 2'd1, 4'd3, mk_ld(0, 1'b1, 1'b0, 32'h0000BBBB));
        set_ld(1, 32'h3001, 2'd0, 4'd2, mk_ld(1, 1'b1, 1'b0, 32'h00000033));
        tick();

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin : rnd
            int cands[$];
            int k, sz, lsz, mk;
            logic [31:0] a, d;
            disp = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) begin
                cands.delete();
                for (int i = 0; i < mq.size(); i++) if (!mq[i].ex) cands.push_back(i);
                if (cands.size() > 0) begin
                    k  = cands[$urandom_range(0, cands.size() - 1)];
                    sz = $urandom_range(0, 2);
                    a  = 32'h1000 + 32'(4 * $urandom_range(0, 3)) + 32'((1 << sz) * $urandom_range(0, (4 >> sz) - 1));
                    d  = $urandom;
                    if (sz < 2) d = d & ((32'd1 << (8 << sz)) - 32'd1);
                    set_exec((head_ptr + k) % D, a, d, 2'(sz));
                end
            end
            if (ncmt < mq.size() && mq[ncmt].ex && $urandom_range(0, 1) == 1) cmit = 1;
            issue_rdy = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    lsz = $urandom_range(0, 2);
                    a   = 32'h1000 + 32'(4 * $urandom_range(0, 3)) + 32'((1 << lsz) * $urandom_range(0, (4 >> lsz) - 1));
                    mk  = (head_ptr + $urandom_range(0, mq.size())) % 16;
                    set_ld(p, a, 2'(lsz), 4'(mk), fwd_ref(p, a, lsz, mk));
                end
            end
            tick();
        end
        issue_rdy = 1;
        repeat (12) tick();
        chk("final_iss_empty", 64'(exp_iss.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
